// File: rtl/mux_arb_if.sv
// Handshake bundle for mux_arb: N input channels in, one registered word out.
// The master side drives the channel inputs and out_ready.
interface mux_arb_if #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned CHANNELS = 4
);
  localparam int unsigned SELW = $clog2(CHANNELS);

  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic                      mode;
  logic [SELW-1:0]           fixed_sel;
  logic [WIDTH-1:0]          out_data;
  logic [SELW-1:0]           out_sel;
  logic                      out_valid;
  logic                      out_ready;

  modport master (
    output in_data, in_valid, mode, fixed_sel, out_ready,
    input  in_ready, out_data, out_sel, out_valid
  );

  modport slave (
    input  in_data, in_valid, mode, fixed_sel, out_ready,
    output in_ready, out_data, out_sel, out_valid
  );
endinterface

// File: rtl/mux_arb.sv
// N-channel registered multiplexer with round-robin or fixed-select arbitration
// into a single valid/ready output register (no skid buffer).
module mux_arb #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned CHANNELS = 4
) (
  input logic      clk,
  input logic      rst,
  mux_arb_if.slave bus
);
  localparam int unsigned SELW = $clog2(CHANNELS);

  logic [SELW-1:0]     last_q;
  logic [SELW-1:0]     out_sel_q;
  logic [WIDTH-1:0]    out_data_q;
  logic                out_valid_q;

  logic [SELW-1:0]     cand;
  logic [SELW-1:0]     rr_idx;
  logic                rr_found;
  logic                fx_found;
  logic [SELW-1:0]     grant_idx;
  logic                grant_valid;
  logic [WIDTH-1:0]    grant_data;
  logic [CHANNELS-1:0] grant_onehot;
  logic                load;
  logic                accept;

  // (base + off) mod CHANNELS, valid for base < CHANNELS and off <= CHANNELS.
  function automatic logic [SELW-1:0] wrap_idx(input logic [SELW-1:0] base,
                                               input int unsigned     off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= CHANNELS) sum = sum - CHANNELS;
    return SELW'(sum);
  endfunction

  // Search starts just after the last accepted channel, so that one has lowest priority.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = '0;
    for (int unsigned off = 1; off <= CHANNELS; off++) begin
      cand = wrap_idx(last_q, off);
      if (!rr_found && bus.in_valid[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
  end

  always_comb begin
    fx_found = 1'b0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (bus.fixed_sel == SELW'(i) && bus.in_valid[i]) fx_found = 1'b1;
    end
  end

  always_comb begin
    if (bus.mode) begin
      grant_valid = fx_found;
      grant_idx   = bus.fixed_sel;
    end else begin
      grant_valid = rr_found;
      grant_idx   = rr_idx;
    end
  end

  always_comb begin
    grant_data   = '0;
    grant_onehot = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (grant_idx == SELW'(i)) begin
        grant_data      = bus.in_data[i*WIDTH +: WIDTH];
        grant_onehot[i] = 1'b1;
      end
    end
  end

  assign load   = !out_valid_q || bus.out_ready;
  assign accept = load && grant_valid && !rst;

  assign bus.in_ready  = accept ? grant_onehot : '0;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.out_valid = out_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      last_q      <= SELW'(CHANNELS - 1);
    end else if (load) begin
      out_valid_q <= grant_valid;
      if (grant_valid) begin
        out_data_q <= grant_data;
        out_sel_q  <= grant_idx;
        last_q     <= grant_idx;
      end
    end
  end
endmodule

// File: tb/tb_mux_arb.sv
// Bench for mux_arb: a 4-channel and a 3-channel instance checked every cycle
// against a queue-free behavioural model, plus directed literal expectations.
module tb_mux_arb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mux_arb_if #(.WIDTH(4), .CHANNELS(4)) bus4 ();
  mux_arb_if #(.WIDTH(4), .CHANNELS(3)) bus3 ();

  mux_arb #(.WIDTH(4), .CHANNELS(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));
  mux_arb #(.WIDTH(4), .CHANNELS(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));

  // Model state per instance: 0 = four channels, 1 = three channels.
  logic       m_valid [2];
  logic [3:0] m_data  [2];
  int         m_sel   [2];
  int         m_last  [2];
  logic       m_known [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Grant chosen by the arbitration rules; -1 when nobody is granted.
  function automatic int exp_grant(input int nch, input logic [3:0] v, input logic m,
                                   input int fsel, input int last);
    if (m) return (fsel < nch && v[fsel]) ? fsel : -1;
    for (int k = 1; k <= nch; k++) begin
      if (v[(last + k) % nch]) return (last + k) % nch;
    end
    return -1;
  endfunction

  task automatic model_step(input int k, input int nch, input logic [3:0] v,
                            input logic [15:0] d, input logic m, input int fsel,
                            input logic ordy, input logic [3:0] a_rdy, input logic a_ov,
                            input logic [3:0] a_od, input int a_os);
    logic       ld;
    int         g;
    logic [3:0] e_rdy;
    string      tag;
    tag   = (k == 0) ? "n4" : "n3";
    ld    = !m_valid[k] || ordy;
    g     = exp_grant(nch, v, m, fsel, m_last[k]);
    e_rdy = (!rst && ld && g >= 0) ? 4'(1 << g) : 4'b0;
    chk({tag, ".in_ready"}, 32'(a_rdy), 32'(e_rdy));
    if (m_known[k]) begin
      chk({tag, ".out_valid"}, 32'(a_ov), 32'(m_valid[k]));
      chk({tag, ".out_data"}, 32'(a_od), 32'(m_data[k]));
      chk({tag, ".out_sel"}, 32'(a_os), 32'(m_sel[k]));
    end
    if (rst) begin
      m_valid[k] = 1'b0;
      m_data[k]  = 4'h0;
      m_sel[k]   = 0;
      m_last[k]  = nch - 1;
      m_known[k] = 1'b1;
    end else if (ld) begin
      m_valid[k] = (g >= 0);
      if (g >= 0) begin
        m_data[k] = d[g*4 +: 4];
        m_sel[k]  = g;
        m_last[k] = g;
      end
    end
  endtask

  // Inputs change 1 time unit after posedge, so the falling edge sees them settled.
  always @(negedge clk) begin
    model_step(0, 4, bus4.in_valid, bus4.in_data, bus4.mode, int'(bus4.fixed_sel),
               bus4.out_ready, bus4.in_ready, bus4.out_valid, bus4.out_data,
               int'(bus4.out_sel));
    model_step(1, 3, {1'b0, bus3.in_valid}, {4'h0, bus3.in_data}, bus3.mode,
               int'(bus3.fixed_sel), bus3.out_ready, {1'b0, bus3.in_ready},
               bus3.out_valid, bus3.out_data, int'(bus3.out_sel));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_valid[k] = 1'b0;
      m_data[k]  = 4'h0;
      m_sel[k]   = 0;
      m_last[k]  = 0;
      m_known[k] = 1'b0;
    end
    bus4.in_data = 16'h4321; bus4.in_valid = '0; bus4.mode = 1'b0;
    bus4.fixed_sel = '0;     bus4.out_ready = 1'b1;
    bus3.in_data = 12'h321;  bus3.in_valid = '0; bus3.mode = 1'b0;
    bus3.fixed_sel = '0;     bus3.out_ready = 1'b1;

    cyc(); cyc();
    rst = 1'b0;
    // Idle after reset: nothing valid, nothing loaded.
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("idle.out_valid", 32'(bus4.out_valid), 32'd0);
      chk("idle.out_data", 32'(bus4.out_data), 32'd0);
    end

    // Round-robin over all four channels from reset priority.
    bus4.in_valid = 4'b1111;
    bus3.in_valid = 3'b111;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("rr4.out_sel", 32'(bus4.out_sel), 32'(i % 4));
      chk("rr4.out_data", 32'(bus4.out_data), 32'(i % 4 + 1));
    end

    // Only channels 1 and 3 competing.
    bus4.in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("rr13.out_sel", 32'(bus4.out_sel), (i % 2 == 0) ? 32'd1 : 32'd3);
    end

    // Backpressure holds the word and blocks every input.
    bus4.in_valid  = 4'b1111;
    bus4.out_ready = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp.in_ready", 32'(bus4.in_ready), 32'd0);
      chk("bp.out_data", 32'(bus4.out_data), 32'd4);
      cyc();
    end
    bus4.out_ready = 1'b1;
    cyc();
    chk("bp.release_sel", 32'(bus4.out_sel), 32'd0);
    chk("bp.release_data", 32'(bus4.out_data), 32'd1);

    // Fixed select; the 3-channel instance gets an out-of-range select.
    bus4.mode = 1'b1; bus4.fixed_sel = 2'd2;
    bus3.mode = 1'b1; bus3.fixed_sel = 2'd3;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("fix.out_sel", 32'(bus4.out_sel), 32'd2);
      chk("fix.out_data", 32'(bus4.out_data), 32'd3);
      chk("fix3.out_valid", 32'(bus3.out_valid), 32'd0);
      chk("fix3.in_ready", 32'(bus3.in_ready), 32'd0);
    end

    // Reset while a word is held and inputs are valid.
    rst = 1'b1;
    #1;
    chk("rst.in_ready", 32'(bus4.in_ready), 32'd0);
    cyc();
    chk("rst.out_valid", 32'(bus4.out_valid), 32'd0);
    rst = 1'b0;
    bus4.mode = 1'b0;
    #1;
    chk("rst.first_ready", 32'(bus4.in_ready), 32'd1);
    cyc();
    chk("rst.first_sel", 32'(bus4.out_sel), 32'd0);

    // Random traffic, occasional reset, both instances.
    for (int i = 0; i < 4000; i++) begin
      rst            = ($urandom_range(0, 63) == 0);
      bus4.in_data   = 16'($urandom);
      bus4.in_valid  = 4'($urandom);
      bus4.mode      = ($urandom_range(0, 3) == 0);
      bus4.fixed_sel = 2'($urandom);
      bus4.out_ready = ($urandom_range(0, 3) != 0);
      bus3.in_data   = 12'($urandom);
      bus3.in_valid  = 3'($urandom);
      bus3.mode      = ($urandom_range(0, 2) == 0);
      bus3.fixed_sel = 2'($urandom_range(0, 3));
      bus3.out_ready = ($urandom_range(0, 2) != 0);
      cyc();
    end
    rst = 1'b0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
